uart_sync_fifo: RTL and testbench

//  Single-clock first-word-fall-through (FWFT) FIFO for the UART TX and RX data paths.
//  - Width and depth are parametrised.
//  - An optional parity bit is stored with each word and checked on read.
//  - Almost-full and almost-empty thresholds are programmable at run time.
//  - A synchronous flush empties the FIFO.
//  - A parity-fault injection input exists for test.
//  - Overflow and underflow are reported as one-cycle pulses.

---
 rtl/uart_sync_fifo.sv | 121 ++++++++++++
 tb/tb_uart_sync_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_sync_fifo.sv
// Single-clock FWFT FIFO for the UART TX/RX data paths.
// Stores an optional even-parity bit per word and checks it at the head.
module uart_sync_fifo #(
  parameter int FIFO_AW            = 4,
  parameter int FIFO_DW            = 8,
  parameter int FIFO_PARITY_ENABLE = 1
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_flush,
  input  logic               i_wr_req,
  input  logic [FIFO_DW-1:0] i_data_in,
  input  logic               i_err_inject,
  input  logic               i_rd_req,
  input  logic [FIFO_AW:0]   i_afull_thr,
  input  logic [FIFO_AW:0]   i_aempty_thr,
  output logic [FIFO_DW-1:0] o_data_out,
  output logic               o_valid,
  output logic               o_parity_error,
  output logic [FIFO_AW:0]   o_used,
  output logic [FIFO_AW:0]   o_free,
  output logic               o_full,
  output logic               o_almost_full,
  output logic               o_empty,
  output logic               o_almost_empty,
  output logic               o_overflow,
  output logic               o_underflow
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int PW    = (FIFO_PARITY_ENABLE != 0) ? 1 : 0;
  localparam int MW    = FIFO_DW + PW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  logic [MW-1:0]      mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic               full, empty;
  logic               wr_ok, rd_ok;
  logic [MW-1:0]      wr_word;
  logic [MW-1:0]      head;

  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);

  // A full FIFO still takes a write when the head is popped in the same cycle.
  assign wr_ok = i_wr_req & ~i_flush & (~full | i_rd_req);
  assign rd_ok = i_rd_req & ~i_flush & ~empty;

  assign head = mem_q[rd_ptr_q];

  if (PW == 1) begin : g_par
    assign wr_word        = {(^i_data_in) ^ i_err_inject, i_data_in};
    assign o_parity_error = ~empty & (^head);
  end else begin : g_nopar
    logic unused_inj;
    assign unused_inj     = i_err_inject;
    assign wr_word        = i_data_in;
    assign o_parity_error = 1'b0;
  end

  // Next-state for pointers, count and the error pulses.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = i_wr_req & ~wr_ok & ~i_flush;
    unf_d    = i_rd_req & ~rd_ok & ~i_flush;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case (1'b1)
        (wr_ok & ~rd_ok): cnt_d = cnt_q + 1'b1;
        (rd_ok & ~wr_ok): cnt_d = cnt_q - 1'b1;
        default:          cnt_d = cnt_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_word;
  end

  assign o_data_out     = empty ? '0 : head[FIFO_DW-1:0];
  assign o_valid        = ~empty;
  assign o_used         = cnt_q;
  assign o_free         = DEPTH_C - cnt_q;
  assign o_full         = full;
  assign o_empty        = empty;
  assign o_almost_full  = (cnt_q >= i_afull_thr);
  assign o_almost_empty = (cnt_q <= i_aempty_thr);
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Bench for uart_sync_fifo: directed scenarios plus random traffic,
// checked every cycle against a queue model (parity on and off).
module tb_uart_sync_fifo;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int D  = 4;

  logic          clk   = 1'b0;
  logic          nrst  = 1'b1;
  logic          flush = 1'b0;
  logic          wr    = 1'b0;
  logic          inj   = 1'b0;
  logic          rd    = 1'b0;
  logic [DW-1:0] din   = '0;
  logic [AW:0]   afthr = 3'd3;
  logic [AW:0]   aethr = 3'd1;

  logic [DW-1:0] dout, dout2;
  logic          valid, valid2, perr, perr2;
  logic [AW:0]   used, used2, free, free2;
  logic          full, full2, afull, afull2;
  logic          empty, empty2, aempty, aempty2;
  logic          ovf, ovf2, unf, unf2;

  uart_sync_fifo #(
    .FIFO_AW(AW), .FIFO_DW(DW), .FIFO_PARITY_ENABLE(1)
  ) u_dut (
    .i_clk(clk), .i_nrst(nrst), .i_flush(flush),
    .i_wr_req(wr), .i_data_in(din), .i_err_inject(inj),
    .i_rd_req(rd), .i_afull_thr(afthr), .i_aempty_thr(aethr),
    .o_data_out(dout), .o_valid(valid), .o_parity_error(perr),
    .o_used(used), .o_free(free), .o_full(full),
    .o_almost_full(afull), .o_empty(empty),
    .o_almost_empty(aempty), .o_overflow(ovf), .o_underflow(unf)
  );

  uart_sync_fifo #(
    .FIFO_AW(AW), .FIFO_DW(DW), .FIFO_PARITY_ENABLE(0)
  ) u_dut_np (
    .i_clk(clk), .i_nrst(nrst), .i_flush(flush),
    .i_wr_req(wr), .i_data_in(din), .i_err_inject(inj),
    .i_rd_req(rd), .i_afull_thr(afthr), .i_aempty_thr(aethr),
    .o_data_out(dout2), .o_valid(valid2), .o_parity_error(perr2),
    .o_used(used2), .o_free(free2), .o_full(full2),
    .o_almost_full(afull2), .o_empty(empty2),
    .o_almost_empty(aempty2), .o_overflow(ovf2), .o_underflow(unf2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    bit         bad;
  } ent_t;

  ent_t q[$];
  bit   m_ovf = 1'b0;
  bit   m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all();
    int         n;
    logic [7:0] hd;
    bit         hb;
    n  = q.size();
    hd = (n > 0) ? q[0].d : 8'h00;
    hb = (n > 0) ? q[0].bad : 1'b0;
    chk("valid",  32'(valid),  32'(n > 0));
    chk("data",   32'(dout),   32'(hd));
    chk("perr",   32'(perr),   32'(hb));
    chk("used",   32'(used),   32'(n));
    chk("free",   32'(free),   32'(D - n));
    chk("full",   32'(full),   32'(n == D));
    chk("empty",  32'(empty),  32'(n == 0));
    chk("afull",  32'(afull),  32'(n >= int'(afthr)));
    chk("aempty", 32'(aempty), 32'(n <= int'(aethr)));
    chk("ovf",    32'(ovf),    32'(m_ovf));
    chk("unf",    32'(unf),    32'(m_unf));
    chk("np_data", 32'(dout2), 32'(hd));
    chk("np_perr", 32'(perr2), 32'd0);
    chk("np_used", 32'(used2), 32'(n));
    chk("np_ovf",  32'(ovf2),  32'(m_ovf));
    chk("np_unf",  32'(unf2),  32'(m_unf));
  endtask

  // Drive one cycle of requests, advance the model on the edge,
  // then compare on the following falling edge.
  task automatic step(input bit w, input logic [7:0] d, input bit e,
                      input bit r, input bit f);
    bit wok, rok;
    wr = w; din = d; inj = e; rd = r; flush = f;
    @(posedge clk);
    if (f) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      wok   = w && (q.size() < D || r);
      rok   = r && (q.size() > 0);
      m_ovf = w && !wok;
      m_unf = r && !rok;
      if (rok) void'(q.pop_front());
      if (wok) q.push_back('{d, e});
    end
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; flush = 1'b0; inj = 1'b0;
    chk_all();
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1 nrst = 1'b0;
    repeat (2) @(negedge clk);
    chk_all();
    nrst = 1'b1;
    idle();

    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle();

    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle();
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    afthr = 3'd3;
    aethr = 3'd1;
    idle();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 3 * D; i++)
      step(1'b1, 8'(8'hC0 + i), 1'b0, (i > 0), 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
    idle();

    step(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    #2 nrst = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    chk_all();
    @(negedge clk);
    nrst = 1'b1;
    idle();

    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        afthr = 3'($urandom_range(0, 5));
        aethr = 3'($urandom_range(0, 5));
      end
      step(($urandom % 2) == 1, 8'($urandom), ($urandom % 4) == 0,
           ($urandom % 2) == 1, ($urandom % 25) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
